ft_restore: RTL and testbench
=============================

Name: ft_restore

Overview:
- Recovery-side consumer of the fault-tolerance controller's halt/replay signalling.
- When the controller halts the lockstep pair after a comparator mismatch, this block reads every entry of the shadow register file (sgpr) through its read port and writes it into both cores' register files. It then reloads the saved PC and hands control back with a resume pulse.
- Sits between the ft module (sgpr read port, spc output, halt_o) and the two cores' register-file/PC write ports.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register and PC data width.
- NUM_REGS, 32, number of registers restored; must be <= 2**ADDR_WIDTH.
- FIRST_REG, 1, first restored index; index 0 is skipped by default (hardwired zero).

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- halt_i  in  1  level; recovery request from the ft controller.
- sgpr_raddr_o  out  ADDR_WIDTH  shadow register file read address.
- sgpr_rdata_i  in  DATA_WIDTH  shadow register file read data; combinational from sgpr_raddr_o.
- spc_i  in  DATA_WIDTH  saved PC from spc.
- rf_waddr_o  out  ADDR_WIDTH  write address, shared by both cores.
- rf_wdata_o  out  DATA_WIDTH  write data, shared.
- rf_we_a_o  out  1  core A register-file write enable.
- rf_we_b_o  out  1  core B register-file write enable.
- rf_ready_i  in  1  both cores accept the write this cycle.
- pc_o  out  DATA_WIDTH  PC restore value.
- pc_we_o  out  1  PC load strobe to both cores.
- busy_o  out  1  restore in progress.
- resume_o  out  1  one-cycle pulse: restore complete.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: sgpr_raddr_o, rf_waddr_o, rf_wdata_o, pc_o, every enable, busy_o, resume_o.
  - Address counter = FIRST_REG.
- FSM states: IDLE, READ, WRITE, PC, DONE.
- IDLE:
  - busy_o=0.
  - On halt_i=1: counter=FIRST_REG, go to READ; busy_o=1 from the next cycle.
- READ:
  - Drive sgpr_raddr_o=counter.
  - At the clock edge, register sgpr_rdata_i into the data register and counter into rf_waddr_o, then go to WRITE.
- WRITE:
  - Assert rf_we_a_o = rf_we_b_o = 1 with the registered address and data.
  - Data and address are held stable while rf_ready_i=0.
  - On rf_ready_i=1 the write is accepted:
    - If counter==NUM_REGS-1, go to PC.
    - Otherwise counter+1 and go to READ.
  - Write enables deassert in the cycle after acceptance.
- PC:
  - pc_o = spc_i, sampled on entry and registered; pc_we_o=1.
  - Handshake on rf_ready_i, same rule as WRITE.
  - After acceptance, go to DONE.
- DONE:
  - resume_o=1 for exactly one cycle, busy_o=0, then go to IDLE.
- Latency: halt_i sampled to resume_o = 2*(NUM_REGS-FIRST_REG)+3 cycles with rf_ready_i tied high. Default: 65.
- Counter width is ADDR_WIDTH and never wraps past NUM_REGS-1.
- halt_i behaviour:
  - halt_i deasserting mid-restore is ignored; a restore always completes.
  - halt_i still high in DONE: resume pulses, then the IDLE sampling of halt_i starts a new restore.
- Write-enable exclusivity: rf_we_a_o and rf_we_b_o are always equal and never high in the same cycle as pc_we_o.
- Reset mid-restore: immediate return to IDLE with all outputs 0; no resume_o.
- Degenerate configuration: FIRST_REG >= NUM_REGS means IDLE goes straight to PC.

Optional Feature:
- Macro: FT_RESTORE_VERIFY_EN.
- When defined:
  - Adds input rf_rdata_i [DATA_WIDTH] (core A read-back at rf_waddr_o).
  - Adds output verify_err_o.
  - Adds state VERIFY after each accepted WRITE: compare rf_rdata_i against the registered data.
  - On mismatch, verify_err_o sets (sticky); it clears only on rst_n or when a new restore starts.
  - Latency rises by one cycle per register.
- When undefined: no extra ports or state; timing exactly as above.

Test Plan:
- Basic restore: sgpr preloaded reg[i]=0xA000_0000+i, spc_i=0x0000_0100, rf_ready_i=1, halt_i pulsed 1 cycle.
  - Expect 31 writes, indices 1..31, with matching data on both we.
  - Then pc_we_o with pc_o=0x100.
  - resume_o exactly 65 cycles after halt sampled.
- Backpressure: rf_ready_i low 3 cycles during the write of reg 5.
  - rf_waddr_o=5 and its data held constant.
  - No skipped or duplicated index.
  - Latency +3.
- Reset mid-restore: rst_n low during the write of reg 10.
  - All outputs 0 in the same cycle.
  - No resume_o.
  - A later halt restarts from reg 1.
- Back-to-back: halt_i held high continuously.
  - Two complete restores separated by resume pulses.
  - busy_o low only in the DONE and IDLE cycles between them.
- Parameter edge: NUM_REGS=4, FIRST_REG=0.
  - Writes to indices 0..3, then PC; latency 11.
- FT_RESTORE_VERIFY_EN: force rf_rdata_i mismatch on reg 7.
  - verify_err_o rises after that verify and stays high.
  - Restore still completes with resume_o.

Source files
------------

// File: rtl/ft_restore.sv
// ----------------------------------------------------------------------------
// ft_restore
// Recovery-side consumer of the fault-tolerance controller's halt signalling.
// On halt_i, every shadow register (sgpr) from FIRST_REG to NUM_REGS-1 is read
// and written into both cores' register files.
// The saved PC is then loaded into both cores and resume_o pulses for one
// cycle.
//
// Optional build macro: FT_RESTORE_VERIFY_EN
//   Adds rf_rdata_i / verify_err_o and a VERIFY state after every accepted
//   register write. The state compares core A's read-back with the written
//   data. verify_err_o is sticky until reset or the start of the next restore.
//
// Ports:
//   clk_i, rst_n   clock, asynchronous active-low reset
//   halt_i         recovery request (level, sampled in IDLE only)
//   sgpr_raddr_o   shadow register file read address
//   sgpr_rdata_i   shadow register file read data (combinational from address)
//   spc_i          saved PC
//   rf_waddr_o     register write address (shared by both cores)
//   rf_wdata_o     register write data (shared)
//   rf_we_a_o      core A register write enable
//   rf_we_b_o      core B register write enable
//   rf_ready_i     both cores accept the current write / PC load
//   pc_o           PC restore value
//   pc_we_o        PC load strobe
//   busy_o         restore in progress
//   resume_o       one-cycle restore-complete pulse
//   rf_rdata_i     (FT_RESTORE_VERIFY_EN) core A read-back at rf_waddr_o
//   verify_err_o   (FT_RESTORE_VERIFY_EN) sticky read-back mismatch flag
// ----------------------------------------------------------------------------
module ft_restore #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int FIRST_REG  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  halt_i,
   output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
   input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
   input  logic [DATA_WIDTH-1:0] spc_i,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  rf_we_a_o,
   output logic                  rf_we_b_o,
   input  logic                  rf_ready_i,
`ifdef FT_RESTORE_VERIFY_EN
   input  logic [DATA_WIDTH-1:0] rf_rdata_i,
   output logic                  verify_err_o,
`endif
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  pc_we_o,
   output logic                  busy_o,
   output logic                  resume_o
);

   localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_REG);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
   // With no registers in range the restore is just a PC reload.
   localparam bit HAS_REGS = (FIRST_REG < NUM_REGS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
`ifdef FT_RESTORE_VERIFY_EN
      S_VERIFY,
`endif
      S_PC,
      S_DONE
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [ADDR_WIDTH-1:0]   r_raddr;
   logic [ADDR_WIDTH-1:0]   r_waddr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic                    r_we;
   logic [DATA_WIDTH-1:0]   r_pc;
   logic                    r_pc_we;
   logic                    r_busy;
   logic                    r_resume;
`ifdef FT_RESTORE_VERIFY_EN
   logic                    r_err;
`endif

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= FIRST_ADDR;
         r_raddr  <= '0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_pc     <= '0;
         r_pc_we  <= 1'b0;
         r_busy   <= 1'b0;
         r_resume <= 1'b0;
`ifdef FT_RESTORE_VERIFY_EN
         r_err    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_busy   <= 1'b0;
               r_resume <= 1'b0;
               if (halt_i) begin
                  r_busy <= 1'b1;
                  r_cnt  <= FIRST_ADDR;
`ifdef FT_RESTORE_VERIFY_EN
                  r_err  <= 1'b0;
`endif
                  if (HAS_REGS) begin
                     r_raddr <= FIRST_ADDR;
                     r_state <= S_READ;
                  end else begin
                     r_pc    <= spc_i;
                     r_pc_we <= 1'b1;
                     r_state <= S_PC;
                  end
               end
            end
            S_READ: begin
               r_wdata <= sgpr_rdata_i;
               r_waddr <= r_cnt;
               r_we    <= 1'b1;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               if (rf_ready_i) begin
                  r_we <= 1'b0;
`ifdef FT_RESTORE_VERIFY_EN
                  r_state <= S_VERIFY;
`else
                  if (r_cnt == LAST_ADDR) begin
                     r_pc    <= spc_i;
                     r_pc_we <= 1'b1;
                     r_state <= S_PC;
                  end else begin
                     r_cnt   <= r_cnt + 1'b1;
                     r_raddr <= r_cnt + 1'b1;
                     r_state <= S_READ;
                  end
`endif
               end
            end
`ifdef FT_RESTORE_VERIFY_EN
            S_VERIFY: begin
               // Address and data are still held, so the read-back refers to
               // the write just accepted.
               if (rf_rdata_i != r_wdata) r_err <= 1'b1;
               if (r_cnt == LAST_ADDR) begin
                  r_pc    <= spc_i;
                  r_pc_we <= 1'b1;
                  r_state <= S_PC;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_raddr <= r_cnt + 1'b1;
                  r_state <= S_READ;
               end
            end
`endif
            S_PC: begin
               if (rf_ready_i) begin
                  r_pc_we  <= 1'b0;
                  r_busy   <= 1'b0;
                  r_resume <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_resume <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sgpr_raddr_o = r_raddr;
   assign rf_waddr_o   = r_waddr;
   assign rf_wdata_o   = r_wdata;
   assign rf_we_a_o    = r_we;
   assign rf_we_b_o    = r_we;
   assign pc_o         = r_pc;
   assign pc_we_o      = r_pc_we;
   assign busy_o       = r_busy;
   assign resume_o     = r_resume;
`ifdef FT_RESTORE_VERIFY_EN
   assign verify_err_o = r_err;
`endif

endmodule

// File: tb/tb_ft_restore.sv
// ----------------------------------------------------------------------------
// tb_ft_restore
// Directed bench for ft_restore. dut0 uses the default parameters and is
// checked every cycle against a queue of expected (index, data) writes and the
// expected PC. dut1 uses NUM_REGS=4, FIRST_REG=0.
// ----------------------------------------------------------------------------
module tb_ft_restore;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef FT_RESTORE_VERIFY_EN
   localparam int LAT_BASIC = 96;   // 3 cycles per register + 3
   localparam int LAT_SMALL = 15;
`else
   localparam int LAT_BASIC = 65;   // 2 cycles per register + 3
   localparam int LAT_SMALL = 11;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          halt0, ready0, halt1, ready1;
   logic [DW-1:0] spc;
   logic [DW-1:0] sgpr [32];

   logic [AW-1:0] raddr0, waddr0, raddr1, waddr1;
   logic [DW-1:0] rdata0, rdata1, wdata0, wdata1, pc0, pc1;
   logic          we_a0, we_b0, pc_we0, busy0, resume0;
   logic          we_a1, we_b1, pc_we1, busy1, resume1;

   assign rdata0 = sgpr[raddr0];
   assign rdata1 = sgpr[raddr1];

`ifdef FT_RESTORE_VERIFY_EN
   logic [DW-1:0] rb0, rb1;
   logic          err0, err1, corrupt;
   assign rb0 = (corrupt && waddr0 == 5'd7) ? (wdata0 ^ 32'h1) : wdata0;
   assign rb1 = wdata1;
`endif

   always #5 clk = ~clk;

   ft_restore dut0 (
      .clk_i(clk), .rst_n(rst_n), .halt_i(halt0),
      .sgpr_raddr_o(raddr0), .sgpr_rdata_i(rdata0), .spc_i(spc),
      .rf_waddr_o(waddr0), .rf_wdata_o(wdata0),
      .rf_we_a_o(we_a0), .rf_we_b_o(we_b0), .rf_ready_i(ready0),
`ifdef FT_RESTORE_VERIFY_EN
      .rf_rdata_i(rb0), .verify_err_o(err0),
`endif
      .pc_o(pc0), .pc_we_o(pc_we0), .busy_o(busy0), .resume_o(resume0)
   );

   ft_restore #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(4), .FIRST_REG(0)) dut1 (
      .clk_i(clk), .rst_n(rst_n), .halt_i(halt1),
      .sgpr_raddr_o(raddr1), .sgpr_rdata_i(rdata1), .spc_i(spc),
      .rf_waddr_o(waddr1), .rf_wdata_o(wdata1),
      .rf_we_a_o(we_a1), .rf_we_b_o(we_b1), .rf_ready_i(ready1),
`ifdef FT_RESTORE_VERIFY_EN
      .rf_rdata_i(rb1), .verify_err_o(err1),
`endif
      .pc_o(pc1), .pc_we_o(pc_we1), .busy_o(busy1), .resume_o(resume1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model of dut0: the writes still owed, in order, and the PC to follow.
   logic [AW-1:0] exp_addr [$];
   logic [DW-1:0] exp_data [$];
   logic [DW-1:0] exp_pc;
   logic          pc_seen, prev_stall, prev_resume;
   logic [AW-1:0] hold_addr;
   logic [DW-1:0] hold_data;

   task automatic load_expect();
      for (int i = 1; i < 32; i++) begin
         exp_addr.push_back(AW'(i));
         exp_data.push_back(sgpr[i]);
      end
      exp_pc = spc;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("we_b_tracks_we_a", we_b0, we_a0);
         chk("we_pc_exclusive", we_a0 & pc_we0, 0);
         if (we_a0 || pc_we0) chk("busy_while_writing", busy0, 1);
         if (prev_stall) begin
            chk("stall_hold_we", we_a0, 1);
            chk("stall_hold_addr", waddr0, hold_addr);
            chk("stall_hold_data", wdata0, hold_data);
         end
         if (we_a0 && ready0) begin
            chk("write_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) begin
               chk("write_addr", waddr0, exp_addr.pop_front());
               chk("write_data", wdata0, exp_data.pop_front());
            end
         end
         if (pc_we0 && ready0) begin
            chk("pc_after_all_writes", exp_addr.size(), 0);
            chk("pc_value", pc0, exp_pc);
            pc_seen = 1'b1;
         end
         chk("resume_one_cycle", prev_resume & resume0, 0);
         if (resume0) begin
            chk("resume_after_pc", pc_seen, 1);
            chk("resume_not_busy", busy0, 0);
            pc_seen = 1'b0;
         end
         prev_stall  = we_a0 && !ready0;
         hold_addr   = waddr0;
         hold_data   = wdata0;
         prev_resume = resume0;
      end
   end

   // Pulses halt0 for one cycle and returns the latency: cycles from the one
   // in which halt is sampled through the resume cycle, both inclusive.
   // ready0 is pulled low for stall_n cycles while the write of stall_reg is
   // pending.
   task automatic run0(input int stall_reg, input int stall_n, output int lat);
      int  n, left;
      bit  got;
      n = 0; left = stall_n; got = 1'b0;
      @(posedge clk); #1 halt0 = 1'b1; ready0 = 1'b1;
      @(posedge clk); #1 halt0 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (resume0) begin got = 1'b1; break; end
         @(posedge clk); n++; #1;
         if (left > 0 && we_a0 && waddr0 == AW'(stall_reg)) begin
            ready0 = 1'b0; left--;
         end else ready0 = 1'b1;
      end
      chk("resume_seen", got, 1);
      lat = n + 2;
   endtask

   initial begin
      int lat, gap, low, k, n, since;
      bit got;
      rst_n = 1'b0; halt0 = 1'b0; halt1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
      spc = 32'h0000_0100;
      pc_seen = 1'b0; prev_stall = 1'b0; prev_resume = 1'b0;
      hold_addr = '0; hold_data = '0; exp_pc = '0;
`ifdef FT_RESTORE_VERIFY_EN
      corrupt = 1'b0;
`endif
      for (int i = 0; i < 32; i++) sgpr[i] = 32'hA000_0000 + i;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_addr_data0", {raddr0, waddr0, wdata0}, 0);
      chk("rst_pc_ctl0", {pc0, pc_we0, we_a0, we_b0, busy0, resume0}, 0);
      chk("rst_ctl1", {we_a1, we_b1, pc_we1, busy1, resume1}, 0);
      rst_n = 1'b1;

      // Basic restore
      load_expect();
      run0(0, 0, lat);
      chk("latency_basic", lat, LAT_BASIC);

      // Backpressure on reg 5
      load_expect();
      run0(5, 3, lat);
      chk("latency_backpressure", lat, LAT_BASIC + 3);

      // Reset during the write of reg 10
      load_expect();
      @(posedge clk); #1 halt0 = 1'b1;
      @(posedge clk); #1 halt0 = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (we_a0 && waddr0 == 5'd10) break;
      end
      chk("reset_reached_reg10", {we_a0, waddr0}, {1'b1, 5'd10});
      rst_n = 1'b0;
      #1;
      chk("midrst_addr_data", {raddr0, waddr0, wdata0}, 0);
      chk("midrst_pc_ctl", {pc0, pc_we0, we_a0, we_b0, busy0, resume0}, 0);
      exp_addr.delete(); exp_data.delete();
      pc_seen = 1'b0; prev_stall = 1'b0; prev_resume = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_resume", resume0, 0);
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("postrst_idle", {busy0, resume0}, 0);
      end
      load_expect();   // restart must begin again at reg 1
      run0(0, 0, lat);
      chk("latency_after_reset", lat, LAT_BASIC);

      // Back-to-back: halt held high across two restores
      load_expect();
      @(posedge clk); #1 halt0 = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (resume0) break;
      end
      chk("b2b_first_resume", resume0, 1);
      load_expect();
      low = busy0 ? 0 : 1;
      gap = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         gap++;
         if (resume0) break;
         if (!busy0) low++;
      end
      halt0 = 1'b0;
      chk("b2b_second_resume", resume0, 1);
      chk("b2b_resume_spacing", gap, LAT_BASIC);
      chk("b2b_busy_low_cycles", low, 2);
      repeat (5) begin
         @(negedge clk);
         chk("b2b_stops_after_release", busy0, 0);
      end

      // dut1: NUM_REGS=4, FIRST_REG=0
      @(posedge clk); #1 halt1 = 1'b1;
      @(posedge clk); #1 halt1 = 1'b0;
      n = 0; k = 0; got = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (we_a1) begin
            chk("small_waddr", waddr1, AW'(k));
            chk("small_wdata", wdata1, sgpr[k]);
            chk("small_we_b", we_b1, 1);
            k++;
         end
         if (pc_we1) begin
            chk("small_pc", pc1, 32'h0000_0100);
            chk("small_write_count", k, 4);
         end
         if (resume1) begin got = 1'b1; break; end
         @(posedge clk); n++;
      end
      chk("small_resume_seen", got, 1);
      chk("small_latency", n + 2, LAT_SMALL);

`ifdef FT_RESTORE_VERIFY_EN
      // Read-back mismatch on reg 7
      corrupt = 1'b1;
      load_expect();
      @(posedge clk); #1 halt0 = 1'b1; ready0 = 1'b1;
      @(posedge clk); #1 halt0 = 1'b0;
      since = -1; got = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (since >= 0) since++;
         chk("verify_err_timing", err0, since >= 2);
         if (we_a0 && ready0 && waddr0 == 5'd7) since = 0;
         if (resume0) begin got = 1'b1; break; end
      end
      chk("verify_resume_seen", got, 1);
      chk("verify_err_sticky", err0, 1);
      corrupt = 1'b0;
      load_expect();
      run0(0, 0, lat);
      chk("verify_err_cleared", err0, 0);
      chk("verify_latency", lat, LAT_BASIC);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
